// File: rtl/perceptron_serial_trainer.sv
// Bit-serial perceptron with on-chip perceptron-rule training.
// One binary input is scanned per cycle against a signed weight into a
// saturating accumulator. The sum is then thresholded against a signed bias.
// In train mode a misclassification nudges the weights and bias by 1<<lr_shift.
module perceptron_serial_trainer #(
    parameter int N_IN      = 16,
    parameter int W_W       = 8,
    parameter int ACC_W     = 10,
    parameter int W_INIT    = 16,
    parameter int BIAS_INIT = -64,
    localparam int AW       = $clog2(N_IN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N_IN-1:0]  x,
    input  logic             train,
    input  logic             target,
    input  logic [2:0]       lr_shift,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [W_W-1:0]   wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [W_W-1:0]   rd_data,
    output logic             busy,
    output logic             done,
    output logic             class_out,
    output logic [ACC_W-1:0] sum_out
);

    localparam int IW = $clog2(N_IN);
    // Update arithmetic is wide enough to hold any weight plus a step of up to 128.
    localparam int UW = ((W_W > 8) ? W_W : 8) + 2;

    localparam logic signed [UW-1:0]  WMAX      = UW'((1 << (W_W - 1)) - 1);
    localparam logic signed [UW-1:0]  WMIN      = ~WMAX;
    localparam logic signed [W_W-1:0] W_INIT_V  = W_W'(W_INIT);
    localparam logic signed [W_W-1:0] B_INIT_V  = W_W'(BIAS_INIT);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SCAN   = 3'd1;
    localparam logic [2:0] S_DECIDE = 3'd2;
    localparam logic [2:0] S_UPDATE = 3'd3;
    localparam logic [2:0] S_BIAS   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]               state_q, state_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [N_IN-1:0]          x_q, x_d;
    logic                     train_q, train_d;
    logic                     target_q, target_d;
    logic [2:0]               lr_q, lr_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  sum_q, sum_d;
    logic                     class_q, class_d;
    logic signed [W_W-1:0]    bias_q, bias_d;
    logic signed [W_W-1:0]    w_q [N_IN];
    logic signed [W_W-1:0]    w_d [N_IN];

    logic signed [ACC_W:0]    total;
    logic                     cls;

    // Accumulate one weight, clamping to the accumulator's signed range.
    function automatic logic signed [ACC_W-1:0] acc_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [W_W-1:0]   w
    );
        logic [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {{(ACC_W + 1 - W_W){w[W_W-1]}}, w};
        if (s[ACC_W] != s[ACC_W-1])
            acc_add = s[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}};
        else
            acc_add = s[ACC_W-1:0];
    endfunction

    // Move a weight/bias up or down by 1<<sh, clamping to the weight range.
    function automatic logic signed [W_W-1:0] step_sat(
        input logic signed [W_W-1:0] v,
        input logic                  up,
        input logic [2:0]            sh
    );
        logic signed [UW-1:0] ext;
        logic signed [UW-1:0] stp;
        logic signed [UW-1:0] r;
        ext = {{(UW - W_W){v[W_W-1]}}, v};
        stp = UW'(1) << sh;
        r   = up ? (ext + stp) : (ext - stp);
        if (r > WMAX)
            step_sat = WMAX[W_W-1:0];
        else if (r < WMIN)
            step_sat = WMIN[W_W-1:0];
        else
            step_sat = r[W_W-1:0];
    endfunction

    // Threshold: accumulator plus bias at one extra bit, strictly positive means class 1.
    always_comb begin
        total = {acc_q[ACC_W-1], acc_q} + {{(ACC_W + 1 - W_W){bias_q[W_W-1]}}, bias_q};
        cls   = !total[ACC_W] && (total != '0);
    end

    // Next-state logic for the controller, datapath and weight store.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        x_d      = x_q;
        train_d  = train_q;
        target_d = target_q;
        lr_d     = lr_q;
        acc_d    = acc_q;
        sum_d    = sum_q;
        class_d  = class_q;
        bias_d   = bias_q;
        w_d      = w_q;
        case (state_q)
            S_IDLE: begin
                // A same-cycle write lands before the scan starts reading weights.
                if (wr_en) begin
                    if (wr_addr < AW'(N_IN))
                        w_d[wr_addr[IW-1:0]] = wr_data;
                    else if (wr_addr == AW'(N_IN))
                        bias_d = wr_data;
                end
                if (start) begin
                    x_d      = x;
                    train_d  = train;
                    target_d = target;
                    lr_d     = lr_shift;
                    acc_d    = '0;
                    idx_d    = '0;
                    state_d  = S_SCAN;
                end
            end
            S_SCAN: begin
                if (x_q[idx_q])
                    acc_d = acc_add(acc_q, w_q[idx_q]);
                if (idx_q == IW'(N_IN - 1)) begin
                    idx_d   = '0;
                    state_d = S_DECIDE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DECIDE: begin
                sum_d   = acc_q;
                class_d = cls;
                idx_d   = '0;
                state_d = (train_q && (cls != target_q)) ? S_UPDATE : S_DONE;
            end
            S_UPDATE: begin
                if (x_q[idx_q])
                    w_d[idx_q] = step_sat(w_q[idx_q], target_q, lr_q);
                if (idx_q == IW'(N_IN - 1)) begin
                    idx_d   = '0;
                    state_d = S_BIAS;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_BIAS: begin
                bias_d  = step_sat(bias_q, target_q, lr_q);
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Controller and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            x_q      <= '0;
            train_q  <= 1'b0;
            target_q <= 1'b0;
            lr_q     <= '0;
            acc_q    <= '0;
            sum_q    <= '0;
            class_q  <= 1'b0;
            bias_q   <= B_INIT_V;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            x_q      <= x_d;
            train_q  <= train_d;
            target_q <= target_d;
            lr_q     <= lr_d;
            acc_q    <= acc_d;
            sum_q    <= sum_d;
            class_q  <= class_d;
            bias_q   <= bias_d;
        end
    end

    // One register per weight so every weight returns to its initial value on reset.
    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_w
            always_ff @(posedge clk) begin
                if (!rst_n)
                    w_q[gi] <= W_INIT_V;
                else
                    w_q[gi] <= w_d[gi];
            end
        end
    endgenerate

    // Combinational readback of weights and bias; unmapped addresses read zero.
    always_comb begin
        rd_data = '0;
        if (rd_addr < AW'(N_IN))
            rd_data = w_q[rd_addr[IW-1:0]];
        else if (rd_addr == AW'(N_IN))
            rd_data = bias_q;
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign class_out = class_q;
    assign sum_out   = sum_q;

endmodule

// File: tb/tb_perceptron_serial_trainer.sv
// Directed bench for perceptron_serial_trainer (N_IN=16, W_W=8, ACC_W=10).
module tb_perceptron_serial_trainer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] x;
    logic        train;
    logic        target;
    logic [2:0]  lr_shift;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [4:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        busy;
    logic        done;
    logic        class_out;
    logic [9:0]  sum_out;

    int checks = 0;
    int errors = 0;

    perceptron_serial_trainer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .x         (x),
        .train     (train),
        .target    (target),
        .lr_shift  (lr_shift),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .class_out (class_out),
        .sum_out   (sum_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] x;
        logic        train;
        logic        target;
        logic [2:0]  lr;
        int          exp_sum;
        logic        exp_cls;
        int          exp_lat;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    task automatic rd(input logic [4:0] a, output int v);
        rd_addr = a;
        #1;
        v = $signed(rd_data);
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    // Launch one operation and count cycles until done. Optional same-cycle write
    // with start, and an optional poke of start (during SCAN) and wr_en (during UPDATE).
    task automatic run(input logic [15:0] xv, input logic tr, input logic tg,
                       input logic [2:0] lr, input logic do_wr, input logic [4:0] wa,
                       input logic [7:0] wd, input logic poke, output int lat);
        @(negedge clk);
        x        = xv;
        train    = tr;
        target   = tg;
        lr_shift = lr;
        start    = 1'b1;
        wr_en    = do_wr;
        wr_addr  = wa;
        wr_data  = wd;
        @(posedge clk);
        #1;
        start = 1'b0;
        wr_en = 1'b0;
        x     = 16'hA5A5;
        lat   = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (poke) begin
                if (c == 3) begin
                    start = 1'b1;
                    x     = 16'h0000;
                end
                if (c == 4) start = 1'b0;
                if (c == 20) begin
                    wr_en   = 1'b1;
                    wr_addr = 5'd0;
                    wr_data = 8'd99;
                end
                if (c == 21) wr_en = 1'b0;
            end
            if (done) begin
                lat = c;
                break;
            end
        end
        start = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int lat;
        int v;

        tbl[0] = '{16'h000F, 1'b0, 1'b0, 3'd0,  64, 1'b0, 18};
        tbl[1] = '{16'h001F, 1'b0, 1'b0, 3'd0,  80, 1'b1, 18};
        tbl[2] = '{16'h0000, 1'b0, 1'b0, 3'd0,   0, 1'b0, 18};
        tbl[3] = '{16'hFFFF, 1'b0, 1'b0, 3'd0, 256, 1'b1, 18};
        tbl[4] = '{16'h001F, 1'b1, 1'b1, 3'd2,  80, 1'b1, 18};
        tbl[5] = '{16'h0003, 1'b1, 1'b0, 3'd1,  32, 1'b0, 18};

        rst_n = 1'b0; start = 1'b0; x = '0; train = 1'b0; target = 1'b0;
        lr_shift = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_class", int'(class_out), 0);
        chk("reset_sum", $signed(sum_out), 0);
        rd(5'd0, v);  chk("reset_w0", v, 16);
        rd(5'd15, v); chk("reset_w15", v, 16);
        rd(5'd16, v); chk("reset_bias", v, -64);
        rd(5'd17, v); chk("rd_out_of_range17", v, 0);
        rd(5'd31, v); chk("rd_out_of_range31", v, 0);

        // Table-driven classifications on reset weights (none of these update)
        for (int i = 0; i < 6; i++) begin
            run(tbl[i].x, tbl[i].train, tbl[i].target, tbl[i].lr, 1'b0, 5'd0, 8'd0, 1'b0, lat);
            chk($sformatf("vec%0d_latency", i), lat, tbl[i].exp_lat);
            chk($sformatf("vec%0d_sum", i), $signed(sum_out), tbl[i].exp_sum);
            chk($sformatf("vec%0d_class", i), int'(class_out), int'(tbl[i].exp_cls));
        end
        rd(5'd0, v);  chk("no_update_w0", v, 16);
        rd(5'd16, v); chk("no_update_bias", v, -64);
        @(negedge clk);
        chk("idle_after_done_busy", int'(busy), 0);

        // Saturating accumulator, both directions
        for (int i = 0; i < 16; i++) wr(5'(i), 8'd127);
        rd(5'd7, v); chk("write_w7_127", v, 127);
        run(16'hFFFF, 1'b0, 1'b0, 3'd0, 1'b0, 5'd0, 8'd0, 1'b0, lat);
        chk("sat_hi_sum", $signed(sum_out), 511);
        chk("sat_hi_class", int'(class_out), 1);
        for (int i = 0; i < 16; i++) wr(5'(i), 8'h80);
        run(16'hFFFF, 1'b0, 1'b0, 3'd0, 1'b0, 5'd0, 8'd0, 1'b0, lat);
        chk("sat_lo_sum", $signed(sum_out), -512);
        chk("sat_lo_class", int'(class_out), 0);

        // Write applied in the same cycle as start is seen by the scan
        do_reset();
        run(16'h0002, 1'b0, 1'b0, 3'd0, 1'b1, 5'd1, 8'd50, 1'b0, lat);
        chk("start_wr_sum", $signed(sum_out), 50);
        chk("start_wr_class", int'(class_out), 0);

        // Training on a misclassified sample, then the same sample again
        do_reset();
        run(16'h000F, 1'b1, 1'b1, 3'd2, 1'b0, 5'd0, 8'd0, 1'b0, lat);
        chk("train_latency", lat, 35);
        chk("train_class", int'(class_out), 0);
        for (int i = 0; i < 4; i++) begin
            rd(5'(i), v); chk($sformatf("train_w%0d", i), v, 20);
        end
        rd(5'd4, v);  chk("train_w4", v, 16);
        rd(5'd16, v); chk("train_bias", v, -60);
        run(16'h000F, 1'b1, 1'b1, 3'd2, 1'b0, 5'd0, 8'd0, 1'b0, lat);
        chk("retrain_latency", lat, 18);
        chk("retrain_class", int'(class_out), 1);
        chk("retrain_sum", $signed(sum_out), 80);
        rd(5'd0, v);  chk("retrain_w0", v, 20);
        rd(5'd16, v); chk("retrain_bias", v, -60);

        // Weight saturation at the top of the range
        wr(5'd0, 8'd126);
        wr(5'd16, 8'h81);
        run(16'h0001, 1'b1, 1'b1, 3'd3, 1'b0, 5'd0, 8'd0, 1'b0, lat);
        chk("wsat_latency", lat, 35);
        chk("wsat_sum", $signed(sum_out), 126);
        rd(5'd0, v);  chk("wsat_w0", v, 127);
        rd(5'd1, v);  chk("wsat_w1", v, 20);
        rd(5'd16, v); chk("wsat_bias", v, -119);

        // start during SCAN and wr_en during UPDATE are ignored
        do_reset();
        run(16'hFFFF, 1'b1, 1'b0, 3'd0, 1'b0, 5'd0, 8'd0, 1'b1, lat);
        chk("poke_latency", lat, 35);
        chk("poke_sum", $signed(sum_out), 256);
        chk("poke_class", int'(class_out), 1);
        rd(5'd0, v);  chk("poke_w0", v, 15);
        rd(5'd9, v);  chk("poke_w9", v, 15);
        rd(5'd16, v); chk("poke_bias", v, -65);

        // Reset in the middle of a scan
        @(negedge clk);
        x = 16'hFFFF; train = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("midscan_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midscan_busy", int'(busy), 0);
        chk("midscan_class", int'(class_out), 0);
        chk("midscan_sum", $signed(sum_out), 0);
        rd(5'd0, v);  chk("midscan_w0", v, 16);
        rd(5'd16, v); chk("midscan_bias", v, -64);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("after_reset_done", int'(done), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
